// File: rtl/plic_arbiter.sv
// Small PLIC-style interrupt arbiter: edge-triggered pending bits, priority/enable/threshold
// gating and a CLAIM/COMPLETE register. The THRESHOLD register exists only with PLIC_THRESHOLD_EN.
module plic_arbiter #(
    parameter logic [23:0] BASE_ADDR = 24'h201000,
    parameter int          N_SRC     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_data,
    input  logic [23:0]      i_address,
    input  logic             i_write,
    input  logic             i_request,
    output logic [7:0]       o_data,
    output logic             o_data_DV,
    input  logic [N_SRC-1:0] i_irq,
    output logic             o_interrupt
);

    localparam int N_PRIO = (N_SRC < 4) ? N_SRC : 4;

    logic [N_SRC-1:0]      irq_reg;
    logic [N_SRC-1:0]      rise;
    logic [N_SRC-1:0]      pending_reg, pending_next;
    logic [N_SRC-1:0]      in_service_reg, in_service_next;
    logic [N_SRC-1:0]      enable_reg, enable_next;
    logic [N_SRC-1:0]      eligible;
    logic [N_SRC-1:0][2:0] prio_reg, prio_next;
    logic [2:0]            threshold;
    logic [2:0]            sel_id;
    logic [2:0]            best_prio;
    logic [7:0]            rd_data;
    logic [7:0]            o_data_reg, o_data_next;
    logic                  o_data_DV_reg;
    logic                  o_interrupt_reg;

    logic       in_win;
    logic [3:0] offset;
    logic       rd_acc, wr_acc;
    logic       claim_hit, complete_hit;

    // The window is assumed 16-byte aligned, so the low nibble is the register offset.
    assign in_win       = (i_address[23:4] == BASE_ADDR[23:4]);
    assign offset       = i_address[3:0];
    assign rd_acc       = i_request & ~i_write & in_win;
    assign wr_acc       = i_request &  i_write & in_win;
    assign claim_hit    = rd_acc && (offset == 4'd4) && (sel_id != 3'd0);
    assign complete_hit = wr_acc && (offset == 4'd4);

    assign rise = i_irq & ~irq_reg;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            localparam logic [2:0] ID3 = 3'(gi + 1);
            localparam logic [7:0] ID8 = 8'(gi + 1);
            logic claimed;
            logic completed;

            assign claimed   = claim_hit && (sel_id == ID3);
            assign completed = complete_hit && (i_data == ID8);

            // A fresh edge wins over a simultaneous claim so that edge is never lost.
            assign pending_next[gi]    = rise[gi] | (pending_reg[gi] & ~claimed);
            assign in_service_next[gi] = claimed | (in_service_reg[gi] & ~completed);

            // Only IDs 1..4 own a PRIO register; any higher ID stays at priority 0.
            if (gi < 4) begin : g_prio
                assign prio_next[gi] = (wr_acc && (offset == 4'(gi))) ? i_data[2:0] : prio_reg[gi];
            end else begin : g_noprio
                assign prio_next[gi] = 3'd0;
            end

            assign eligible[gi] = pending_reg[gi] & enable_reg[gi] & ~in_service_reg[gi]
                                & (prio_reg[gi] > threshold);
        end
    endgenerate

    assign enable_next = (wr_acc && (offset == 4'd8)) ? i_data[N_SRC-1:0] : enable_reg;

`ifdef PLIC_THRESHOLD_EN
    logic [2:0] threshold_reg, threshold_next;

    assign threshold_next = (wr_acc && (offset == 4'd10)) ? i_data[2:0] : threshold_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            threshold_reg <= 3'd0;
        end else begin
            threshold_reg <= threshold_next;
        end
    end

    assign threshold = threshold_reg;
`else
    assign threshold = 3'd0;
`endif

    // Descending scan with >= lets the lower ID win priority ties.
    always_comb begin
        sel_id    = 3'd0;
        best_prio = 3'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible[k] && (prio_reg[k] >= best_prio)) begin
                best_prio = prio_reg[k];
                sel_id    = 3'(k + 1);
            end
        end
    end

    always_comb begin
        rd_data = 8'd0;
        case (offset)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                for (int k = 0; k < N_PRIO; k++) begin
                    if (offset == 4'(k)) begin
                        rd_data = {5'd0, prio_reg[k]};
                    end
                end
            end
            4'd4:    rd_data = {5'd0, sel_id};
            4'd8:    rd_data[N_SRC-1:0] = enable_reg;
            4'd9:    rd_data[N_SRC-1:0] = pending_reg;
            4'd10:   rd_data = {5'd0, threshold};
            default: rd_data = 8'd0;
        endcase
    end

    // Writes and out-of-window reads still complete, but return zero.
    assign o_data_next = rd_acc ? rd_data : 8'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_reg         <= '0;
            pending_reg     <= '0;
            in_service_reg  <= '0;
            enable_reg      <= '0;
            prio_reg        <= '0;
            o_data_reg      <= 8'd0;
            o_data_DV_reg   <= 1'b0;
            o_interrupt_reg <= 1'b0;
        end else begin
            irq_reg         <= i_irq;
            pending_reg     <= pending_next;
            in_service_reg  <= in_service_next;
            enable_reg      <= enable_next;
            prio_reg        <= prio_next;
            o_data_reg      <= o_data_next;
            o_data_DV_reg   <= i_request;
            o_interrupt_reg <= |eligible;
        end
    end

    assign o_data      = o_data_reg;
    assign o_data_DV   = o_data_DV_reg;
    assign o_interrupt = o_interrupt_reg;

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed bench for plic_arbiter: register access, arbitration order, edge/claim races and reset abort.
module tb_plic_arbiter;

    localparam logic [23:0] BASE = 24'h201000;
    localparam int          NS   = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    data_in;
    logic [23:0]   address;
    logic          write;
    logic          request;
    logic [7:0]    data_out;
    logic          data_dv;
    logic [NS-1:0] irq;
    logic          interrupt;

    int checks   = 0;
    int failures = 0;

    plic_arbiter #(.BASE_ADDR(BASE), .N_SRC(NS)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (data_in),
        .i_address   (address),
        .i_write     (write),
        .i_request   (request),
        .o_data      (data_out),
        .o_data_DV   (data_dv),
        .i_irq       (irq),
        .o_interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] d);
        @(negedge clk);
        address = BASE + {16'd0, off};
        data_in = d;
        write   = 1'b1;
        request = 1'b1;
        @(negedge clk);
        request = 1'b0;
        write   = 1'b0;
        chk("wr_dv", {7'd0, data_dv}, 8'd1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [7:0] exp, input string tag);
        @(negedge clk);
        address = BASE + {16'd0, off};
        write   = 1'b0;
        request = 1'b1;
        @(negedge clk);
        request = 1'b0;
        chk(tag, data_out, exp);
        chk({tag, "_dv"}, {7'd0, data_dv}, 8'd1);
    endtask

    task automatic pulse(input logic [NS-1:0] mask);
        @(negedge clk);
        irq = mask;
        @(negedge clk);
        irq = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 8'd0;
        address = 24'd0;
        write   = 1'b0;
        request = 1'b0;
        irq     = '0;
        repeat (2) @(negedge clk);
        chk("rst_data", data_out, 8'd0);
        chk("rst_dv", {7'd0, data_dv}, 8'd0);
        chk("rst_intr", {7'd0, interrupt}, 8'd0);
        rst_n = 1'b1;

        // Basic claim / complete on source 1
        wr(8'd0, 8'd3);
        wr(8'd8, 8'h01);
        rd(8'd0, 8'd3, "prio1_rd");
        pulse(4'b0001);
        chk("intr_lat1", {7'd0, interrupt}, 8'd0);
        @(negedge clk);
        chk("intr_lat2", {7'd0, interrupt}, 8'd1);
        rd(8'd9, 8'h01, "pend_set");
        rd(8'd4, 8'd1, "claim1");
        @(negedge clk);
        chk("dv_one_cycle", {7'd0, data_dv}, 8'd0);
        chk("intr_fall", {7'd0, interrupt}, 8'd0);
        rd(8'd9, 8'h00, "pend_clr");
        // A new edge while in service is latched but not eligible yet
        pulse(4'b0001);
        @(negedge clk);
        chk("intr_in_svc", {7'd0, interrupt}, 8'd0);
        rd(8'd9, 8'h01, "pend_in_svc");
        wr(8'd4, 8'd1);
        chk("intr_cmp0", {7'd0, interrupt}, 8'd0);
        @(negedge clk);
        chk("intr_cmp1", {7'd0, interrupt}, 8'd1);
        rd(8'd4, 8'd1, "reclaim1");
        wr(8'd4, 8'd1);

        // Priority ordering
        wr(8'd2, 8'd5);
        wr(8'd0, 8'd2);
        wr(8'd8, 8'h05);
        pulse(4'b0101);
        rd(8'd9, 8'h05, "pend_13");
        rd(8'd4, 8'd3, "claim_p5");
        rd(8'd4, 8'd1, "claim_p2");
        rd(8'd4, 8'd0, "claim_none");
        rd(8'd9, 8'h00, "pend_none");
        wr(8'd4, 8'd9);
        wr(8'd4, 8'd3);
        wr(8'd4, 8'd1);

        // Equal priority: lower ID wins
        wr(8'd1, 8'd4);
        wr(8'd3, 8'd4);
        wr(8'd8, 8'h0A);
        rd(8'd8, 8'h0A, "enable_rd");
        pulse(4'b1010);
        rd(8'd4, 8'd2, "claim_tie");
        rd(8'd4, 8'd4, "claim_tie2");
        wr(8'd4, 8'd2);
        wr(8'd4, 8'd4);

        // Unmapped, out-of-window and read-only locations
        rd(8'd5, 8'd0, "unmapped");
        rd(8'h10, 8'd0, "out_of_win");
        wr(8'd9, 8'hFF);
        rd(8'd9, 8'h00, "pend_ro");

`ifdef PLIC_THRESHOLD_EN
        wr(8'd8, 8'h01);
        wr(8'd0, 8'd4);
        wr(8'd10, 8'd4);
        pulse(4'b0001);
        @(negedge clk);
        chk("thr_block", {7'd0, interrupt}, 8'd0);
        wr(8'd10, 8'd3);
        chk("thr_pass0", {7'd0, interrupt}, 8'd0);
        @(negedge clk);
        chk("thr_pass1", {7'd0, interrupt}, 8'd1);
        rd(8'd10, 8'd3, "thr_rd");
        rd(8'd4, 8'd1, "thr_claim");
        wr(8'd4, 8'd1);
        wr(8'd10, 8'd0);
`else
        wr(8'd10, 8'd7);
        rd(8'd10, 8'd0, "thr_absent");
`endif

        // Edge coinciding with a claim of the same source
        wr(8'd8, 8'h01);
        wr(8'd0, 8'd3);
        pulse(4'b0001);
        @(negedge clk);
        address = BASE + 24'd4;
        write   = 1'b0;
        request = 1'b1;
        irq     = 4'b0001;
        @(negedge clk);
        request = 1'b0;
        irq     = '0;
        chk("race_claim", data_out, 8'd1);
        rd(8'd9, 8'h01, "race_pend");
        chk("race_intr", {7'd0, interrupt}, 8'd0);
        wr(8'd4, 8'd1);
        @(negedge clk);
        chk("race_reelig", {7'd0, interrupt}, 8'd1);
        rd(8'd4, 8'd1, "race_reclaim");
        wr(8'd4, 8'd1);

        // Reset asserted in the middle of an access
        pulse(4'b0001);
        @(negedge clk);
        chk("pre_rst_intr", {7'd0, interrupt}, 8'd1);
        address = BASE + 24'd4;
        write   = 1'b0;
        request = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_data", data_out, 8'd0);
        chk("abort_dv", {7'd0, data_dv}, 8'd0);
        chk("abort_intr", {7'd0, interrupt}, 8'd0);
        request = 1'b0;
        @(negedge clk);
        chk("abort_dv2", {7'd0, data_dv}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_dv3", {7'd0, data_dv}, 8'd0);
        rd(8'd9, 8'h00, "rst_pend");
        rd(8'd0, 8'h00, "rst_prio");
        rd(8'd8, 8'h00, "rst_enable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plic_arbiter.md
PLIC_ARBITER -- requirements
Module: plic_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h201000, base of the 16-byte register window.
REQ-002 SHALL have parameter N_SRC, default 4, number of interrupt sources (IDs 1..N_SRC, max 7).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_data input 8 (write byte), i_address input 24 (byte address), i_write input 1 (1 = write), i_request input 1 (one-cycle access strobe).
REQ-006 SHALL have ports o_data output 8 (registered read byte) and o_data_DV output 1 (access-complete pulse).
REQ-007 SHALL have port i_irq  input  N_SRC  source lines; bit k is ID k+1.
REQ-008 SHALL have port o_interrupt  output  1  level interrupt to the hart.

Function
REQ-009 SHALL map these registers: BASE+0..3 PRIO[1..4] (3 bits, R/W); BASE+4 CLAIM/COMPLETE; BASE+8 ENABLE (bits N_SRC-1:0, R/W); BASE+9 PENDING (RO); BASE+10 THRESHOLD (3 bits, R/W).
REQ-010 SHALL set pending[k] on a rising edge of i_irq[k], detected against a one-cycle registered copy.
REQ-011 SHALL treat source k as eligible when pending, enabled, not in-service, and PRIO[k] > THRESHOLD; PRIO 0 is never eligible.
REQ-012 SHALL select the eligible source with highest PRIO; ties go to the lowest ID; no eligible source gives ID 0.
REQ-013 SHALL drive o_interrupt registered, high the cycle after any source becomes eligible, low the cycle after none remains.
REQ-014 SHALL, on i_request with i_write=0 at BASE+4, return the selected ID in o_data, clear its pending bit, and set its in-service bit, all on that edge.
REQ-015 SHALL, on a CLAIM read returning 0, change no state.
REQ-016 SHALL, on i_request with i_write=1 at BASE+4, clear in-service[i_data-1] if that bit is set; any other value SHALL be ignored.
REQ-017 SHALL register o_data and pulse o_data_DV high for exactly one cycle on the edge after any i_request (read or write, in or out of the window).
REQ-018 SHALL read 0 from unmapped, out-of-window, or write-only bits, and SHALL ignore writes to PENDING and to unmapped addresses.
REQ-019 SHALL give a new edge precedence when it coincides with a claim of the same source: pending stays 1 and in-service is set.
REQ-020 SHALL latch a new edge into pending while the source is in-service, so the source is re-eligible after completion.
REQ-021 SHALL, when complete and claim fall in consecutive cycles on the same ID, make the source eligible again the cycle after complete.
REQ-022 SHALL take a PRIO, ENABLE, or THRESHOLD write into effect for arbitration on the cycle after the write.

Reset
REQ-023 SHALL, while i_rst_n=0, hold PRIO=0, ENABLE=0, THRESHOLD=0, pending=0, in-service=0, edge registers=0, o_data=0, o_data_DV=0, and o_interrupt=0.
REQ-024 SHALL abort any access in flight when reset asserts mid-access; no o_data_DV pulse SHALL follow.

Configuration
REQ-025 SHALL compile the THRESHOLD register only when macro PLIC_THRESHOLD_EN is defined.
REQ-026 SHALL, without PLIC_THRESHOLD_EN, fix THRESHOLD at 0, read BASE+10 as 0, and ignore writes to it.

Verification
REQ-027 SHALL cover: PRIO1=3, ENABLE=0x01, pulse i_irq[0] -> o_interrupt=1 two cycles later; CLAIM read -> o_data=1, DV next cycle, o_interrupt falls; write 1 to CLAIM -> in-service clear.
REQ-028 SHALL cover: PRIO1=2, PRIO3=5, both pending and enabled -> CLAIM=3; then CLAIM=1; then CLAIM=0.
REQ-029 SHALL cover: PRIO2=4, PRIO4=4, both pending -> CLAIM=2 (tie goes to lower ID).
REQ-030 SHALL cover: with PLIC_THRESHOLD_EN, THRESHOLD=4, PRIO1=4 pending -> o_interrupt=0; set THRESHOLD=3 -> o_interrupt=1. Without the macro, BASE+10 reads 0 after writing 7.
REQ-031 SHALL cover: rising edge on i_irq[0] in the same cycle as claim of ID 1 -> PENDING bit0=1 after the claim, and source 1 is re-eligible after writing 1 to CLAIM.
REQ-032 SHALL cover: i_rst_n low mid-access with a source pending -> all outputs 0, PENDING=0, and no DV pulse.
